// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: grants one of NREQ requesters per clock into a shared
// WIDTH-bit register that drives q and its registered complement qbar.
// A requester granted on the previous edge is masked for one edge.
// Optional feature macro: ARB_ROUND_ROBIN_EN selects rotating priority.
// Without the macro, the lowest eligible index wins and no pointer exists.
module reg_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  upd,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qbar
);

  logic [NREQ-1:0]  elig;
  logic             found;
  logic [NREQ-1:0]  win_oh;
  logic [WIDTH-1:0] win_data;

`ifdef ARB_ROUND_ROBIN_EN
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;

  // Winner search starts at ptr and wraps; first eligible index wins
  always_comb begin
    elig     = req & ~gnt;
    found    = 1'b0;
    win_oh   = '0;
    win_data = '0;
    ptr_nxt  = ptr;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && elig[idx]) begin
        found       = 1'b1;
        win_oh[idx] = 1'b1;
        win_data    = wdata[idx*WIDTH +: WIDTH];
        ptr_nxt     = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  // Pointer only advances when a write commits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= ptr_nxt;
    end
  end
`else
  // Fixed priority: scan downward so the lowest eligible index wins last
  always_comb begin
    elig     = req & ~gnt;
    found    = 1'b0;
    win_oh   = '0;
    win_data = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found     = 1'b1;
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_data  = wdata[i*WIDTH +: WIDTH];
      end
    end
  end
`endif

  // Grant, pulse, value and complement all commit on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt  <= '0;
      upd  <= 1'b0;
      q    <= '0;
      qbar <= '1;
    end else if (found) begin
      gnt  <= win_oh;
      upd  <= 1'b1;
      q    <= win_data;
      qbar <= ~win_data;
    end else begin
      gnt  <= '0;
      upd  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter: directed scenarios plus randomized traffic,
// each cycle compared against a reference model built from the arbitration
// rules (index arithmetic on the last granted requester and next-start pointer).
module tb_reg_write_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic                  upd;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      qbar;

  int n_tests;
  int n_fail;

  // reference model state
  int               m_last;   // index granted on the previous edge, -1 if none
  int               m_ptr;    // where the round-robin search starts
  logic [WIDTH-1:0] m_q;

  reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .upd   (upd),
    .q     (q),
    .qbar  (qbar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_last = -1;
    m_ptr  = 0;
    m_q    = '0;
  endtask

  // One clock edge: predict, advance, then compare all outputs with the model
  task automatic step(input string tag);
    int w;
    logic [NREQ-1:0] exp_gnt;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
`ifdef ARB_ROUND_ROBIN_EN
      j = (m_ptr + k) % NREQ;
`else
      j = k;
`endif
      if (w < 0 && req[j] === 1'b1 && j != m_last) w = j;
    end
    if (w >= 0) begin
      m_last = w;
      m_q    = wdata[w*WIDTH +: WIDTH];
      m_ptr  = (w + 1) % NREQ;
    end else begin
      m_last = -1;
    end
    exp_gnt = '0;
    if (m_last >= 0) exp_gnt[m_last] = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (gnt !== exp_gnt) begin
      n_fail++;
      $display("FAIL %s gnt: got %b required %b", tag, gnt, exp_gnt);
    end
    n_tests++;
    if (upd !== (m_last >= 0)) begin
      n_fail++;
      $display("FAIL %s upd: got %b required %b", tag, upd, (m_last >= 0));
    end
    n_tests++;
    if (q !== m_q) begin
      n_fail++;
      $display("FAIL %s q: got %h required %h", tag, q, m_q);
    end
    n_tests++;
    if (qbar !== ~m_q) begin
      n_fail++;
      $display("FAIL %s qbar: got %h required %h", tag, qbar, ~m_q);
    end
  endtask

  // Clean reset pulse between edges; leaves inputs idle
  task automatic do_reset();
    req   = '0;
    @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
    #3 rst = 1'b0;
  endtask

  task automatic test_reset();
    req   = '0;
    wdata = '0;
    rst   = 1'b1;
    model_reset();
    #12 rst = 1'b0;
    req   = 4'b1111;
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    step("rst_pre0");
    step("rst_pre1");
    // assert reset between edges: outputs must clear without a clock
    #3 rst = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (gnt !== 4'b0000 || upd !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async ctl: got gnt=%b upd=%b required 0000/0", gnt, upd);
    end
    n_tests++;
    if (q !== 8'h00 || qbar !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_async data: got q=%h qbar=%h required 00/ff", q, qbar);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (gnt !== 4'b0000 || upd !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: got gnt=%b upd=%b required 0000/0", gnt, upd);
    end
    #2 rst = 1'b0;
    step("rst_release");
  endtask

  task automatic test_single();
    logic [3:0] upd_exp;
    do_reset();
    upd_exp = 4'b0101;
    wdata = {8'h00, 8'hA5, 8'h00, 8'h00};
    req   = 4'b0100;
    for (int e = 0; e < 4; e++) begin
      step("single");
      n_tests++;
      if (upd !== upd_exp[e]) begin
        n_fail++;
        $display("FAIL single_upd edge%0d: got %b required %b", e + 1, upd, upd_exp[e]);
      end
      n_tests++;
      if (q !== 8'hA5 || qbar !== 8'h5A) begin
        n_fail++;
        $display("FAIL single_q edge%0d: got %h/%h required a5/5a", e + 1, q, qbar);
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    wdata = {8'h13, 8'h12, 8'h11, 8'h10};
`ifdef ARB_ROUND_ROBIN_EN
    req = 4'b1111;
    for (int e = 0; e < 5; e++) begin
      logic [3:0] eg;
      logic [7:0] eq;
      eg = 4'b0001 << (e % 4);
      eq = 8'h10 + 8'(e % 4);
      step("rr");
      n_tests++;
      if (gnt !== eg || q !== eq) begin
        n_fail++;
        $display("FAIL rr_seq edge%0d: got gnt=%b q=%h required %b/%h", e + 1, gnt, q, eg, eq);
      end
    end
`else
    req = 4'b1011;
    for (int e = 0; e < 6; e++) begin
      logic [3:0] eg;
      eg = (e % 2 == 0) ? 4'b0001 : 4'b0010;
      step("fixed");
      n_tests++;
      if (gnt !== eg) begin
        n_fail++;
        $display("FAIL fixed_seq edge%0d: got %b required %b", e + 1, gnt, eg);
      end
    end
`endif
  endtask

  task automatic test_wrap_idle();
    logic [WIDTH-1:0] held;
    do_reset();
    wdata = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    req   = 4'b0100;
    step("wrap_g2");
    req   = 4'b1001;
    step("wrap_next");
`ifdef ARB_ROUND_ROBIN_EN
    n_tests++;
    if (gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap_search: got %b required 1000", gnt);
    end
`endif
    held = q;
    req  = '0;
    for (int e = 0; e < 2; e++) begin
      step("idle");
      n_tests++;
      if (upd !== 1'b0 || q !== held) begin
        n_fail++;
        $display("FAIL idle_hold: got upd=%b q=%h required 0/%h", upd, q, held);
      end
    end
    req = 4'b1001;
    step("after_idle");
    n_tests++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL after_idle_gnt: got %b required 0001", gnt);
    end
  endtask

  task automatic test_x_data();
    logic [WIDTH-1:0] xd;
    do_reset();
    xd    = 8'bxxxx_0000;
    wdata = {8'h00, 8'h00, 8'h3C, xd};
    req   = 4'b0001;
    step("xdata");
    n_tests++;
    if (q[3:0] !== 4'h0 || qbar[3:0] !== 4'hF) begin
      n_fail++;
      $display("FAIL xdata_low: got q=%b qbar=%b required xxxx0000/xxxx1111", q, qbar);
    end
    req = 4'b0010;
    step("xclean");
    n_tests++;
    if ((q ^ qbar) !== 8'hFF) begin
      n_fail++;
      $display("FAIL xclean_inv: got %h required ff", q ^ qbar);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      req   = 4'($urandom);
      wdata = {$urandom};
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        #2 rst = 1'b0;
      end
      step("random");
      n_tests++;
      if ((q ^ qbar) !== 8'hFF || !$onehot0(gnt)) begin
        n_fail++;
        $display("FAIL random_invariant: got q^qbar=%h gnt=%b required ff/onehot0", q ^ qbar, gnt);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    req     = '0;
    wdata   = '0;
    model_reset();
    test_reset();
    test_single();
    test_priority();
    test_wrap_idle();
    test_x_data();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Shared-register write arbiter: takes up to NREQ requesters, each presenting a write request and data word, and grants exactly one writer per clock into a single WIDTH-bit D-type register bank with complementary outputs. It sits in front of the shared flop storage, sequences all writes into it, and ensures fairness between requesters. Grant, q and qbar update together on the same rising edge, so downstream logic sees a consistent value and its complement at all times.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, data width of the shared register
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester write request; bit i belongs to requester i
- wdata  input  NREQ*WIDTH  write data; requester i owns bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  registered one-hot grant; high for exactly one cycle per committed write
- upd  output  1  registered pulse; equals |gnt
- q  output  WIDTH  shared register contents
- qbar  output  WIDTH  bitwise complement of q, registered

## Operation
- Internal state: gnt register, rotating priority pointer ptr (clog2(NREQ) bits), q register, qbar register.
- Eligible set at each rising edge: req & ~gnt. A requester granted in the current cycle is masked, so no requester is granted on two consecutive edges.
- Eligible set empty: gnt <= 0, upd <= 0, q and qbar hold, ptr holds.
- Eligible set non-empty: select winner w (see Configuration). Then:
  - gnt <= one-hot(w) and upd <= 1.
  - q <= wdata[w] and qbar <= ~wdata[w].
  - ptr <= (w+1) mod NREQ.
- Handshake:
  - Requester raises req with stable wdata.
  - Requester sees gnt[i]=1 in the cycle after its data was captured.
  - Requester must drop req or present new data in that cycle. Masking guarantees its next write commits no earlier than the following edge.
- X/Z on the winning wdata propagates: q takes the X bits and qbar takes ~X (X). No sanitisation is performed.
- req bits deasserted before a grant are simply not considered. No request is latched internally.

## Timing
- Reset (async, rst=1): gnt=0, upd=0, q=0, qbar={WIDTH{1}}, ptr=0. Outputs change immediately without a clock.
- Reset deassertion: first arbitration happens on the first rising edge with rst=0.
- Reset asserted mid-grant: gnt clears immediately and the pending write is lost. q returns to 0.
- Latency is one edge from req sampled high (and eligible) to gnt/q/qbar valid.
- Throughput is one write per cycle when at least two requesters alternate. A single requester is limited to one write every 2 cycles.
- Wrap-around: with ptr=NREQ-1, the search order is NREQ-1, 0, 1, ...
- Invariant: q ^ qbar == all ones at every non-X state. gnt is always zero-hot or one-hot.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - w is the first eligible index searching ptr, ptr+1, ... mod NREQ.
  - ptr updates as described in Operation.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: w is the lowest eligible index.
  - ptr is not implemented, and the ptr-dependent rules above do not apply.
  - All other behaviour is identical.

## Test plan
- Reset:
  - Stimulus: assert rst asynchronously between edges while req=4'b1111.
  - Required response: gnt=0, upd=0, q=8'h00 and qbar=8'hFF immediately; no grant until after release.
- Single requester:
  - Stimulus: req=4'b0100, wdata[2]=8'hA5 held for 4 edges.
  - Required response: grants on edges 1 and 3 only. q=8'hA5, qbar=8'h5A after edge 1; upd pattern 1,0,1,0.
- Round robin (ARB_ROUND_ROBIN_EN defined):
  - Stimulus: req=4'b1111 held, wdata[i]=8'h10+i.
  - Required response: gnt sequence 0001, 0010, 0100, 1000, 0001; q sequence 10, 11, 12, 13, 10.
- Fixed priority (ARB_ROUND_ROBIN_EN undefined):
  - Stimulus: req=4'b1011 held.
  - Required response: gnt alternates 0001, 0010, 0001, ... Requester 3 is never granted.
- Wrap and idle:
  - Stimulus: grant requester 3, then hold req=0 for 2 cycles, then req=4'b1001.
  - Required response: q holds during idle and upd=0. Next grant goes to requester 0 (round-robin build).
- X data:
  - Stimulus: winning wdata=8'bxxxx_0000.
  - Required response: q=8'bxxxx_0000 and qbar=8'bxxxx_1111. The next clean write restores q ^ qbar = 8'hFF.
